// File: rtl/bsg_mc_throttle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsg_mc_throttle_pkg
// Description : Shared types for the manycore link credit throttle. Holds the
//               throttle FSM state encoding and a helper that sizes the
//               credit counter from the outstanding-request limit.
// Revision    : 1.0 - initial release
// ============================================================================
package bsg_mc_throttle_pkg;

    // Link throttle operating states.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } throttle_state_e;

    // Bits needed to hold a credit count in the range 0..max_out.
    function automatic int credit_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage : bsg_mc_throttle_pkg
`default_nettype wire

// File: rtl/bsg_manycore_link_credit_throttle_if.sv
`default_nettype none
// ============================================================================
// Module      : bsg_manycore_link_credit_throttle_if
// Description : Bundle of the throttle's link-side signals: upstream forward
//               channel, downstream forward channel, response credit return,
//               drain control and status.
//               slave  modport : used by the throttle itself
//               master modport : used by the surrounding tile / router side
//               With BSG_MC_CREDIT_THROTTLE_PERF_EN defined the bundle also
//               carries the 32-bit stall counter stall_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
interface bsg_manycore_link_credit_throttle_if
    import bsg_mc_throttle_pkg::*;
#(
    parameter int width_p   = 0,
    parameter int max_out_p = 16
);
    localparam int c_credit_w = credit_width(max_out_p);

    logic                   fwd_v_i;
    logic [width_p-1:0]     fwd_data_i;
    logic                   fwd_ready_o;
    logic                   fwd_v_o;
    logic [width_p-1:0]     fwd_data_o;
    logic                   fwd_ready_i;
    logic                   rev_yumi_i;
    logic                   drain_i;
    logic                   drained_o;
    logic [c_credit_w-1:0]  credits_o;
`ifdef BSG_MC_CREDIT_THROTTLE_PERF_EN
    logic [31:0]            stall_cnt_o;

    modport slave (
        input  fwd_v_i, fwd_data_i, fwd_ready_i, rev_yumi_i, drain_i,
        output fwd_ready_o, fwd_v_o, fwd_data_o, drained_o, credits_o, stall_cnt_o
    );
    modport master (
        output fwd_v_i, fwd_data_i, fwd_ready_i, rev_yumi_i, drain_i,
        input  fwd_ready_o, fwd_v_o, fwd_data_o, drained_o, credits_o, stall_cnt_o
    );
`else
    modport slave (
        input  fwd_v_i, fwd_data_i, fwd_ready_i, rev_yumi_i, drain_i,
        output fwd_ready_o, fwd_v_o, fwd_data_o, drained_o, credits_o
    );
    modport master (
        output fwd_v_i, fwd_data_i, fwd_ready_i, rev_yumi_i, drain_i,
        input  fwd_ready_o, fwd_v_o, fwd_data_o, drained_o, credits_o
    );
`endif

endinterface : bsg_manycore_link_credit_throttle_if
`default_nettype wire

// File: rtl/bsg_mc_throttle_two_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bsg_mc_throttle_two_fifo
// Description : Two-entry ready/valid FIFO. ready_o depends only on the fill
//               level, so there is no combinational path from the output side
//               back to the input side, and a full-rate stream is sustained
//               with one entry resident (enqueue and dequeue every cycle).
// Ports       : clk_i, reset_n_i (async, active-low)
//               v_i / data_i / ready_o  : enqueue side
//               v_o / data_o / ready_i  : dequeue side
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_mc_throttle_two_fifo #(
    parameter int width_p = 0
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i
);
    logic [width_p-1:0] r_mem [2];
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic               w_enq;
    logic               w_deq;

    assign ready_o = (r_count != 2'd2);
    assign v_o     = (r_count != 2'd0);
    assign data_o  = r_mem[r_rd_ptr];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = v_o & ready_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_enq) r_wr_ptr <= ~r_wr_ptr;
            if (w_deq) r_rd_ptr <= ~r_rd_ptr;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage carries no reset: occupancy alone decides validity,
    // so resetting the count is enough to discard stale packets.
    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_wr_ptr] <= data_i;
    end

endmodule : bsg_mc_throttle_two_fifo
`default_nettype wire

// File: rtl/bsg_manycore_link_credit_throttle.sv
`default_nettype none
// ============================================================================
// Module      : bsg_manycore_link_credit_throttle
// Description : Credit-based throttle between a manycore tile and its link.
//               Forward packets pass through a 2-entry buffer and launch only
//               while credits remain; each launch consumes a credit and each
//               returned response (rev_yumi_i) restores one. A drain request
//               stops acceptance and reports drained_o once the buffer is
//               empty and every credit has come home.
// Ports       : clk_i      - clock
//               reset_n_i  - asynchronous active-low reset
//               link       - bsg_manycore_link_credit_throttle_if.slave
//                            (forward in/out, credit return, drain, status)
// Options     : BSG_MC_CREDIT_THROTTLE_PERF_EN adds link.stall_cnt_o, a
//               saturating count of cycles a packet waits for credit.
// Revision    : 1.0 - initial release
// ============================================================================
module bsg_manycore_link_credit_throttle
    import bsg_mc_throttle_pkg::*;
#(
    parameter int width_p   = 0,
    parameter int max_out_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_manycore_link_credit_throttle_if.slave link
);
    localparam int                    c_credit_w    = credit_width(max_out_p);
    localparam logic [c_credit_w-1:0] c_max_credits = c_credit_w'(max_out_p);
    localparam logic [c_credit_w-1:0] c_one_credit  = c_credit_w'(1);

    throttle_state_e        r_state;
    throttle_state_e        w_state_next;
    logic                   r_live;
    logic                   r_drained;
    logic [c_credit_w-1:0]  r_credits;
    logic [c_credit_w-1:0]  w_credits_next;

    logic                   w_accept_en;
    logic                   w_fifo_ready;
    logic                   w_fifo_v;
    logic [width_p-1:0]     w_fifo_data;
    logic                   w_credit_avail;
    logic                   w_all_credits;
    logic                   w_launch;

    assign w_credit_avail = (r_credits != '0);
    assign w_all_credits  = (r_credits == c_max_credits);
    assign w_launch       = w_fifo_v & w_credit_avail & link.fwd_ready_i;

    // Upstream valid is masked outside RUN so the buffer only ever sees
    // packets that the throttle has actually offered ready for.
    bsg_mc_throttle_two_fifo #(
        .width_p (width_p)
    ) u_buf (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (link.fwd_v_i & w_accept_en),
        .data_i    (link.fwd_data_i),
        .ready_o   (w_fifo_ready),
        .v_o       (w_fifo_v),
        .data_o    (w_fifo_data),
        .ready_i   (w_credit_avail & link.fwd_ready_i)
    );

    assign link.fwd_ready_o = w_fifo_ready & w_accept_en;
    assign link.fwd_v_o     = w_fifo_v & w_credit_avail;
    assign link.fwd_data_o  = w_fifo_data;
    assign link.drained_o   = r_drained;
    assign link.credits_o   = r_credits;

    // ---------------------------------------------------------------- FSM
    // r_live holds fwd_ready_o low while reset is asserted and releases it
    // on the first clock edge after reset deasserts.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= RUN;
            r_live    <= 1'b0;
            r_drained <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_live    <= 1'b1;
            r_drained <= (w_state_next == DRAINED);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN: begin
                if (link.drain_i) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (!link.drain_i)                  w_state_next = RUN;
                else if (!w_fifo_v && w_all_credits) w_state_next = DRAINED;
            end
            DRAINED: begin
                if (!link.drain_i) w_state_next = RUN;
            end
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        w_accept_en = 1'b0;
        case (r_state)
            RUN:     w_accept_en = r_live;
            default: w_accept_en = 1'b0;
        endcase
    end

    // -------------------------------------------------------- credit count
    // A return arriving with all credits home is a protocol error; the count
    // pins at max rather than wrapping.
    always_comb begin
        w_credits_next = r_credits;
        case ({w_launch, link.rev_yumi_i})
            2'b10: w_credits_next = r_credits - c_one_credit;
            2'b01: if (!w_all_credits) w_credits_next = r_credits + c_one_credit;
            default: w_credits_next = r_credits;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_credits <= c_max_credits;
        else            r_credits <= w_credits_next;
    end

    a_no_excess_credit : assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        !(link.rev_yumi_i && w_all_credits)
    );

`ifdef BSG_MC_CREDIT_THROTTLE_PERF_EN
    // ------------------------------------------------------- stall counter
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_stall_cnt <= 32'd0;
        end else if (w_fifo_v && !w_credit_avail && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign link.stall_cnt_o = r_stall_cnt;
`endif

endmodule : bsg_manycore_link_credit_throttle
`default_nettype wire

// File: tb/tb_bsg_manycore_link_credit_throttle.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_manycore_link_credit_throttle
// Description : Self-checking bench for the link credit throttle (width 8,
//               four outstanding requests). A queue-based reference model
//               tracks buffered packets, credits and drain mode; directed
//               scenarios are followed by a randomized stream.
//               Define BSG_MC_CREDIT_THROTTLE_PERF_EN to cover stall_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsg_manycore_link_credit_throttle;

    localparam int MAX       = 4;
    localparam int M_RUN     = 0;
    localparam int M_DRAIN   = 1;
    localparam int M_DRAINED = 2;

    logic clk;
    logic reset_n;

    bsg_manycore_link_credit_throttle_if #(.width_p(8), .max_out_p(MAX)) link_if ();

    bsg_manycore_link_credit_throttle #(
        .width_p   (8),
        .max_out_p (MAX)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .link      (link_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_q[$];
    int          m_cred;
    int          m_mode;
    bit          m_live;
    int unsigned m_stall;
    bit          last_accept;
    bit          last_launch;

    int n_vec;
    int n_err;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit rdy, input bit yumi, input bit drn);
        link_if.fwd_v_i    = v;
        link_if.fwd_data_i = d;
        link_if.fwd_ready_i = rdy;
        link_if.rev_yumi_i = yumi;
        link_if.drain_i    = drn;
    endtask

    // One clock cycle: apply inputs, compare outputs to the model, then
    // advance the model by the spec's rules at the clock edge.
    task automatic cycle(input bit v, input logic [7:0] d, input bit rdy, input bit yumi, input bit drn);
        bit exp_ready, exp_v, acc, lau, stall;
        int nxt_mode;
        @(negedge clk);
        drive(v, d, rdy, yumi, drn);
        #1;
        exp_ready = m_live && (m_mode == M_RUN) && (m_q.size() < 2);
        exp_v     = (m_q.size() > 0) && (m_cred > 0);
        check_value("fwd_ready_o", 32'(link_if.fwd_ready_o), 32'(exp_ready));
        check_value("fwd_v_o", 32'(link_if.fwd_v_o), 32'(exp_v));
        if (exp_v) check_value("fwd_data_o", 32'(link_if.fwd_data_o), 32'(m_q[0]));
        check_value("credits_o", 32'(link_if.credits_o), 32'(m_cred));
        check_value("drained_o", 32'(link_if.drained_o), 32'(m_mode == M_DRAINED));
`ifdef BSG_MC_CREDIT_THROTTLE_PERF_EN
        check_value("stall_cnt_o", link_if.stall_cnt_o, m_stall);
`endif
        acc   = v && exp_ready;
        lau   = exp_v && rdy;
        stall = (m_q.size() > 0) && (m_cred == 0);
        nxt_mode = m_mode;
        if (m_mode == M_RUN && drn) nxt_mode = M_DRAIN;
        else if (m_mode == M_DRAIN && !drn) nxt_mode = M_RUN;
        else if (m_mode == M_DRAIN && m_q.size() == 0 && m_cred == MAX) nxt_mode = M_DRAINED;
        else if (m_mode == M_DRAINED && !drn) nxt_mode = M_RUN;
        @(posedge clk);
        if (lau) void'(m_q.pop_front());
        if (acc) m_q.push_back(d);
        if (lau && !yumi) m_cred--;
        else if (yumi && !lau && m_cred < MAX) m_cred++;
        if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
        m_mode      = nxt_mode;
        last_accept = acc;
        last_launch = lau;
    endtask

    // Asynchronous reset in the middle of a cycle, then release.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        check_value("rst_fwd_v_o", 32'(link_if.fwd_v_o), 32'd0);
        check_value("rst_fwd_ready_o", 32'(link_if.fwd_ready_o), 32'd0);
        check_value("rst_drained_o", 32'(link_if.drained_o), 32'd0);
        check_value("rst_credits_o", 32'(link_if.credits_o), 32'(MAX));
`ifdef BSG_MC_CREDIT_THROTTLE_PERF_EN
        check_value("rst_stall_cnt_o", link_if.stall_cnt_o, 32'd0);
`endif
        m_q.delete();
        m_cred  = MAX;
        m_mode  = M_RUN;
        m_live  = 1'b0;
        m_stall = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        m_live = 1'b1;
        check_value("rst_release_ready", 32'(link_if.fwd_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int launches;
        int first_l;
        int last_l;
        bit drn;
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        m_cred = MAX; m_mode = M_RUN; m_live = 1'b0; m_stall = 0;
        repeat (2) @(negedge clk);
        do_reset();

        // Throughput: 6 back-to-back packets, no responses.
        idx = 0; launches = 0; first_l = -1; last_l = -1;
        for (int c = 0; c < 10; c++) begin
            cycle(idx < 6, 8'(8'h10 + idx), 1'b1, 1'b0, 1'b0);
            if (last_accept) idx++;
            if (last_launch) begin
                launches++;
                if (first_l < 0) first_l = c;
                last_l = c;
            end
        end
        #1;
        check_value("thru_accepted", 32'(idx), 32'd6);
        check_value("thru_launches", 32'(launches), 32'd4);
        check_value("thru_consecutive", 32'(last_l - first_l + 1), 32'd4);
        check_value("thru_credits", 32'(link_if.credits_o), 32'd0);
        check_value("thru_ready", 32'(link_if.fwd_ready_o), 32'd0);

        // Credit return: one yumi at zero credits buys exactly one launch.
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        launches = 0;
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            if (last_launch) launches++;
        end
        check_value("yumi_one_launch", 32'(launches), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        #1;
        check_value("launch_yumi_credits", 32'(link_if.credits_o), 32'd2);

        // Backpressure: downstream stalled for 10 cycles, 3 packets offered.
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            cycle(idx < 3, 8'(8'h20 + idx), 1'b0, 1'b0, 1'b0);
            if (last_accept) idx++;
        end
        #1;
        check_value("bp_buffered", 32'(idx), 32'd2);
        check_value("bp_credits", 32'(link_if.credits_o), 32'd2);
        check_value("bp_head_data", 32'(link_if.fwd_data_o), 32'h20);

        // Drain with 2 buffered and 3 outstanding.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, m_cred < MAX, 1'b1);
        for (int c = 0; c < 12; c++) begin
            #1;
            check_value("drain_ready", 32'(link_if.fwd_ready_o), 32'd0);
            cycle(1'b1, 8'h40, 1'b1, m_cred < MAX, 1'b1);
        end
        #1;
        check_value("drain_done", 32'(link_if.drained_o), 32'd1);
        check_value("drain_credits", 32'(link_if.credits_o), 32'(MAX));
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        check_value("undrain_drained", 32'(link_if.drained_o), 32'd0);
        check_value("undrain_ready", 32'(link_if.fwd_ready_o), 32'd1);

        // Reset mid-stream with 2 buffered and one credit left.
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_cred == 1 && m_q.size() == 2) break;
            cycle(1'b1, 8'(8'h50 + idx), m_cred > 1, 1'b0, 1'b0);
            if (last_accept) idx++;
        end
        #1;
        check_value("pre_rst_credits", 32'(link_if.credits_o), 32'd1);
        do_reset();
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        check_value("rst_no_stale", 32'(link_if.fwd_v_o), 32'd0);

`ifdef BSG_MC_CREDIT_THROTTLE_PERF_EN
        // Stall counter: 7 cycles parked at zero credits with a packet held.
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_cred == 0) break;
            cycle(1'b1, 8'(8'h60 + idx), 1'b1, 1'b0, 1'b0);
            if (last_accept) idx++;
        end
        for (int c = 0; c < 7; c++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        check_value("stall_cnt_7", link_if.stall_cnt_o, 32'd7);
`endif

        // Randomized traffic with drain toggling and one reset.
        drn = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) drn = !drn;
            cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 3) != 0,
                  (m_cred < MAX) && ($urandom_range(0, 2) == 0), drn);
            if (c == 200) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bsg_manycore_link_credit_throttle
`default_nettype wire
